timer_master_ctrl: RTL and testbench
====================================

Name: timer_master_ctrl

Overview:
- Avalon-MM master that drives the team's 16-bit interval-timer slave register map (status 0, control 1, period_l 2, period_h 3, snap_l 4, snap_h 5).
- On a start pulse it programs the period, starts the timer, then services each timeout interrupt: clear status, snapshot, read back the snapshot.
- Counts timeout events and stops the timer when done.
- Sits between a local control FSM/CPU-less datapath and the timer slave on the same clock.

Parameters:
- MAX_EVENTS, 16'd4, number of timeouts serviced in continuous mode before auto-stop; 0 = unlimited.
- ADDR_W, 3, Avalon address width (word addresses).
- DATA_W, 16, Avalon data width; fixed at 16, other values unsupported.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- stop  in  1  one-cycle request to end the current run.
- period_in  in  32  timer period, latched on accepted start.
- continuous  in  1  1 = continuous mode, 0 = one-shot; latched on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the run ends.
- event_count  out  16  timeouts serviced this run, saturating at 0xFFFF.
- snapshot  out  32  last snapshot read from the timer.
- snapshot_valid  out  1  one-cycle pulse when snapshot updates.
- avm_address  out  ADDR_W  slave register address.
- avm_chipselect  out  1  bus cycle active.
- avm_write_n  out  1  active-low write; 1 with chipselect = read.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  slave read data, registered in the slave; valid exactly 1 cycle after the address is presented.
- irq_in  in  1  timer interrupt, level.

Behaviour:
- Reset values: busy=0, done=0, event_count=0, snapshot=0, snapshot_valid=0, chipselect=0, write_n=1, address=0, writedata=0, state=IDLE, stop_pending=0.
- Every bus access is a single-cycle transfer (no waitrequest). chipselect is high only in the access states below; write_n=0 only in write states.
- FSM:
  - IDLE: on start, latch period_in/continuous, clear event_count and stop_pending, busy=1, go to WR_PL.
  - WR_PL: write addr 2, data period[15:0].
  - WR_PH: write addr 3, data period[31:16].
  - WR_CTRL: write addr 1, data {STOP=0, START=1, CONT=continuous, ITO=1}, i.e. 0x7 continuous / 0x5 one-shot.
  - WAIT_IRQ: bus idle; on irq_in go to CLR. If stop or stop_pending, go to WR_STOP instead; stop has priority over a simultaneous irq_in.
  - CLR: write addr 0, data 0.
  - SNAP: write addr 4, data 0.
  - RD_L: read addr 4.
  - CAP_L: capture readdata into snapshot[15:0], issue read addr 5.
  - CAP_H: capture snapshot[31:16], pulse snapshot_valid, increment event_count (saturating).
  - DECIDE:
    - One-shot: go to WR_STOP.
    - Continuous: go to WR_STOP if stop_pending, or if MAX_EVENTS≠0 and event_count==MAX_EVENTS.
    - Otherwise return to WAIT_IRQ.
  - WR_STOP: write addr 1, data 0x8.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- A stop pulse in any busy state other than WAIT_IRQ sets stop_pending; it is honoured at the next WAIT_IRQ/DECIDE.
- A stop pulse in IDLE is ignored.
- A start pulse while busy is ignored and does not re-latch period_in.
- Latency: start to first control write is 4 cycles (IDLE, WR_PL, WR_PH, WR_CTRL); each interrupt service is 6 bus-state cycles.
- irq_in is level. After the CLR write the slave drops irq one cycle later, so WAIT_IRQ is never re-entered while the stale irq is still high.
- Reset asserted mid-run: all outputs return to reset values immediately. The slave is reset by the same reset_n.

Decomposition:
- Shared package timer_regs_pkg:
  - register address constants TMR_STATUS=0, TMR_CONTROL=1, TMR_PERIOD_L=2, TMR_PERIOD_H=3, TMR_SNAP_L=4, TMR_SNAP_H=5;
  - control bit indices ITO=0, CONT=1, START=2, STOP=3;
  - the FSM state enum.
- One sub-module is natural: avm_single_access, which drives one write or one read-with-1-cycle-capture from a command. The FSM sequences commands through it.

Test Plan:
- Reset, then start with period_in=9 and continuous=0 against the timer slave:
  - bus writes are addr2=0x0009, addr3=0x0000, addr1=0x5;
  - after irq, writes are addr0 then addr4;
  - reads return snapshot=0x00000009 with snapshot_valid pulsing once;
  - event_count=1, last write addr1=0x8, done pulses, busy=0.
- Start with continuous=1, MAX_EVENTS=4, period 0x0001_0000: high word written 0x0001; exactly 4 irq services occur, then stop write, event_count=4.
- Continuous run, stop pulsed during RD_L: the current service completes (snapshot_valid pulses), then WR_STOP follows at DECIDE; no fifth service.
- stop and irq_in high in the same WAIT_IRQ cycle: FSM goes to WR_STOP, no status clear, event_count unchanged.
- Second start pulse while busy with different period_in: ignored; no extra period writes are issued.
- reset_n dropped during WAIT_IRQ: chipselect=0, write_n=1, busy=0, event_count=0 in the same cycle; a later start runs a clean sequence.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// Shared definitions for the interval-timer master: slave register map,
// control-word bit positions, the sequencing FSM states and the bus
// command record handed from the FSM to the single-access bus driver.
package timer_regs_pkg;

  // Slave register map (word addresses)
  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;
  localparam logic [2:0] TMR_SNAP_L   = 3'd4;
  localparam logic [2:0] TMR_SNAP_H   = 3'd5;

  // Control register bit indices
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_WAIT_IRQ,
    ST_CLR,
    ST_SNAP,
    ST_RD_L,
    ST_CAP_L,
    ST_CAP_H,
    ST_DECIDE,
    ST_WR_STOP,
    ST_FIN
  } tmr_state_e;

  // One bus access: vld=0 means the bus is idle for that cycle
  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] dat;
  } avm_cmd_t;

  localparam avm_cmd_t CMD_IDLE = '0;

  function automatic avm_cmd_t cmd_write(input logic [2:0] addr, input logic [15:0] dat);
    avm_cmd_t c;
    c.vld  = 1'b1;
    c.wr   = 1'b1;
    c.addr = addr;
    c.dat  = dat;
    return c;
  endfunction

  function automatic avm_cmd_t cmd_read(input logic [2:0] addr);
    avm_cmd_t c;
    c.vld  = 1'b1;
    c.wr   = 1'b0;
    c.addr = addr;
    c.dat  = 16'h0000;
    return c;
  endfunction

  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w        = 16'h0000;
    w[STOP]  = stop;
    w[START] = start;
    w[CONT]  = cont;
    w[ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/avm_single_access.sv
// Drives one single-cycle Avalon-MM access per cycle from a registered command.
// Latency: bus pins follow the command the same cycle; read data flagged 1 cycle later.
// Backpressure: none, the slave has no waitrequest so every access completes in one cycle.
module avm_single_access #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_vld,
  input  logic              cmd_wr,
  input  logic [2:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_dat,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_dat
);

  // The command is already a register in the FSM, so the pins stay glitch-free
  assign avm_address    = ADDR_W'(cmd_addr);
  assign avm_chipselect = cmd_vld;
  assign avm_write_n    = ~(cmd_vld & cmd_wr);
  assign avm_writedata  = cmd_dat;
  assign rd_dat         = avm_readdata;

  // Slave registers its read data, so it is usable the cycle after a read address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= cmd_vld & ~cmd_wr;
    end
  end

endmodule

// File: rtl/timer_master_ctrl.sv
// Avalon-MM master sequencing the 16-bit interval timer: program, start, service timeouts, stop.
// Latency: start to control write 4 cycles; each timeout service takes 6 cycles.
// Backpressure: start ignored while busy; stop deferred to the next WAIT_IRQ/DECIDE point.
module timer_master_ctrl
  import timer_regs_pkg::*;
#(
  parameter logic [15:0] MAX_EVENTS = 16'd4,
  parameter int          ADDR_W     = 3,
  parameter int          DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period_in,
  input  logic              continuous,
  output logic              busy,
  output logic              done,
  output logic [15:0]       event_count,
  output logic [31:0]       snapshot,
  output logic              snapshot_valid,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              irq_in
);

  tmr_state_e  state;
  avm_cmd_t    cmd;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pending;
  logic        rd_vld;
  logic [15:0] rd_dat;
  logic        max_reached;

  assign max_reached = (MAX_EVENTS != 16'd0) && (event_count == MAX_EVENTS);

  avm_single_access #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bus (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_vld        (cmd.vld),
    .cmd_wr         (cmd.wr),
    .cmd_addr       (cmd.addr),
    .cmd_dat        (cmd.dat),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .rd_vld         (rd_vld),
    .rd_dat         (rd_dat)
  );

  // Sequencer: the bus command for a state is registered on entry to that state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cmd            <= CMD_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      event_count    <= 16'h0000;
      snapshot       <= 32'h0000_0000;
      snapshot_valid <= 1'b0;
      stop_pending   <= 1'b0;
      period_q       <= 32'h0000_0000;
      cont_q         <= 1'b0;
    end else begin
      done           <= 1'b0;
      snapshot_valid <= 1'b0;

      // WAIT_IRQ acts on stop directly; elsewhere it is remembered
      if (busy && stop && (state != ST_WAIT_IRQ)) begin
        stop_pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          cmd <= CMD_IDLE;
          if (start) begin
            period_q     <= period_in;
            cont_q       <= continuous;
            event_count  <= 16'h0000;
            stop_pending <= 1'b0;
            busy         <= 1'b1;
            cmd          <= cmd_write(TMR_PERIOD_L, period_in[15:0]);
            state        <= ST_WR_PL;
          end
        end
        ST_WR_PL: begin
          cmd   <= cmd_write(TMR_PERIOD_H, period_q[31:16]);
          state <= ST_WR_PH;
        end
        ST_WR_PH: begin
          cmd   <= cmd_write(TMR_CONTROL, ctrl_word(1'b0, 1'b1, cont_q, 1'b1));
          state <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          cmd   <= CMD_IDLE;
          state <= ST_WAIT_IRQ;
        end
        ST_WAIT_IRQ: begin
          // A stop wins over a simultaneous timeout: no service is started
          if (stop || stop_pending) begin
            cmd   <= cmd_write(TMR_CONTROL, ctrl_word(1'b1, 1'b0, 1'b0, 1'b0));
            state <= ST_WR_STOP;
          end else if (irq_in) begin
            cmd   <= cmd_write(TMR_STATUS, 16'h0000);
            state <= ST_CLR;
          end else begin
            cmd   <= CMD_IDLE;
          end
        end
        ST_CLR: begin
          cmd   <= cmd_write(TMR_SNAP_L, 16'h0000);
          state <= ST_SNAP;
        end
        ST_SNAP: begin
          cmd   <= cmd_read(TMR_SNAP_L);
          state <= ST_RD_L;
        end
        ST_RD_L: begin
          cmd   <= cmd_read(TMR_SNAP_H);
          state <= ST_CAP_L;
        end
        ST_CAP_L: begin
          if (rd_vld) begin
            snapshot[15:0] <= rd_dat;
          end
          cmd   <= CMD_IDLE;
          state <= ST_CAP_H;
        end
        ST_CAP_H: begin
          if (rd_vld) begin
            snapshot[31:16] <= rd_dat;
          end
          snapshot_valid <= 1'b1;
          if (event_count != 16'hFFFF) begin
            event_count <= event_count + 16'd1;
          end
          cmd   <= CMD_IDLE;
          state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (!cont_q || stop_pending || max_reached) begin
            cmd   <= cmd_write(TMR_CONTROL, ctrl_word(1'b1, 1'b0, 1'b0, 1'b0));
            state <= ST_WR_STOP;
          end else begin
            cmd   <= CMD_IDLE;
            state <= ST_WAIT_IRQ;
          end
        end
        ST_WR_STOP: begin
          cmd   <= CMD_IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_FIN;
        end
        ST_FIN: begin
          cmd   <= CMD_IDLE;
          state <= ST_IDLE;
        end
        default: begin
          cmd   <= CMD_IDLE;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_master_ctrl.sv
// Directed-plus-random bench for timer_master_ctrl against a behavioural timer slave.
// Expected bus traffic is built as a list of (addr,data) writes from the run rules.
// Snapshot values are random and supplied by the slave model.
module tb_timer_master_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [31:0] period_in;
  logic        continuous;
  logic        busy;
  logic        done;
  logic [15:0] event_count;
  logic [31:0] snapshot;
  logic        snapshot_valid;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        irq_in;

  int checks;
  int failures;

  // slave model state
  logic        irq_fire;
  logic [31:0] snap_src;
  logic [31:0] snap_reg;
  int          sv_cnt;
  logic [18:0] wr_q[$];
  logic [18:0] exp_q[$];

  timer_master_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .period_in      (period_in),
    .continuous     (continuous),
    .busy           (busy),
    .done           (done),
    .event_count    (event_count),
    .snapshot       (snapshot),
    .snapshot_valid (snapshot_valid),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .irq_in         (irq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer slave: level irq cleared by a status write, snapshot latched by a snap write,
  // registered read data
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_in       <= 1'b0;
      snap_reg     <= 32'h0;
      avm_readdata <= 16'h0;
    end else begin
      if (irq_fire) irq_in <= 1'b1;
      if (avm_chipselect && !avm_write_n) begin
        if (avm_address == 3'd0) irq_in <= 1'b0;
        if (avm_address == 3'd4) snap_reg <= snap_src;
      end
      if (avm_chipselect && avm_write_n) begin
        case (avm_address)
          3'd4:    avm_readdata <= snap_reg[15:0];
          3'd5:    avm_readdata <= snap_reg[31:16];
          default: avm_readdata <= 16'h0;
        endcase
      end
    end
  end

  // Bus write log and snapshot pulse counter
  always @(posedge clk) begin
    if (reset_n && avm_chipselect && !avm_write_n) wr_q.push_back({avm_address, avm_writedata});
    if (reset_n && snapshot_valid) sv_cnt <= sv_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a run is header writes, two writes per serviced timeout, then the stop write
  task automatic build_expected(input logic [31:0] per, input bit cont, input int n_svc);
    exp_q.delete();
    exp_q.push_back({3'd2, per[15:0]});
    exp_q.push_back({3'd3, per[31:16]});
    exp_q.push_back({3'd1, cont ? 16'h0007 : 16'h0005});
    for (int i = 0; i < n_svc; i++) begin
      exp_q.push_back({3'd0, 16'h0000});
      exp_q.push_back({3'd4, 16'h0000});
    end
    exp_q.push_back({3'd1, 16'h0008});
  endtask

  task automatic compare_log(input string tag, input int base);
    int n;
    n = wr_q.size() - base;
    check($sformatf("%s_wr_count", tag), n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[base+i], exp_q[i]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] per, input logic cont);
    start = 1'b1; period_in = per; continuous = cont;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic fire_irq(input logic [31:0] v);
    snap_src = v; irq_fire = 1'b1;
    @(negedge clk);
    irq_fire = 1'b0;
  endtask

  task automatic wait_sv(input string tag);
    int n = 0;
    while (!snapshot_valid && n < 200) begin @(negedge clk); n++; end
    check(tag, snapshot_valid, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (wr_q.size() < n && k < 200) begin @(negedge clk); k++; end
    check(tag, wr_q.size() >= n, 1'b1);
  endtask

  initial begin
    int base, sv0;
    logic [31:0] per, per2, v;
    checks = 0; failures = 0; sv_cnt = 0;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; period_in = '0; continuous = 1'b0;
    irq_fire = 1'b0; snap_src = '0;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_event_count", event_count, 16'h0);
    check("rst_snapshot", snapshot, 32'h0);
    check("rst_snapshot_valid", snapshot_valid, 1'b0);
    check("rst_chipselect", avm_chipselect, 1'b0);
    check("rst_write_n", avm_write_n, 1'b1);
    check("rst_address", avm_address, 3'd0);
    check("rst_writedata", avm_writedata, 16'h0);

    // stop while idle does nothing
    pulse_stop();
    repeat (2) @(negedge clk);
    check("idle_stop_busy", busy, 1'b0);
    check("idle_stop_cs", avm_chipselect, 1'b0);

    // one-shot, period 9, with latency checks on the header writes
    base = wr_q.size(); sv0 = sv_cnt;
    pulse_start(32'd9, 1'b0);
    check("os_wrpl_addr", avm_address, 3'd2);
    check("os_wrpl_wr", {avm_chipselect, avm_write_n}, 2'b10);
    check("os_busy", busy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("os_ctrl_addr", avm_address, 3'd1);
    check("os_ctrl_data", avm_writedata, 16'h0005);
    fire_irq(32'h0000_0009);
    wait_done("os");
    build_expected(32'd9, 1'b0, 1);
    compare_log("os", base);
    check("os_snapshot", snapshot, 32'h0000_0009);
    check("os_sv_pulses", sv_cnt - sv0, 1);
    check("os_event_count", event_count, 16'd1);

    // continuous, auto-stop after 4 services, fifth timeout ignored
    per = 32'h0001_0000;
    base = wr_q.size(); sv0 = sv_cnt;
    pulse_start(per, 1'b1);
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      fire_irq(v);
      wait_sv($sformatf("cont_sv%0d", i));
      check($sformatf("cont_snap%0d", i), snapshot, v);
      check($sformatf("cont_evt%0d", i), event_count, i + 1);
    end
    fire_irq($urandom);
    wait_done("cont");
    build_expected(per, 1'b1, 4);
    compare_log("cont", base);
    check("cont_event_count", event_count, 16'd4);
    check("cont_sv_pulses", sv_cnt - sv0, 4);
    do_reset();

    // stop during RD_L: service finishes, then stop at DECIDE
    per = $urandom;
    base = wr_q.size(); sv0 = sv_cnt;
    pulse_start(per, 1'b1);
    v = $urandom;
    fire_irq(v);
    wait_sv("rdl_sv0");
    check("rdl_snap0", snapshot, v);
    v = $urandom;
    fire_irq(v);
    begin
      int k = 0;
      while (!(avm_chipselect && avm_write_n && avm_address == 3'd4) && k < 100) begin
        @(negedge clk); k++;
      end
      check("rdl_found", avm_chipselect && avm_write_n && avm_address == 3'd4, 1'b1);
    end
    pulse_stop();
    wait_sv("rdl_sv1");
    check("rdl_snap1", snapshot, v);
    fire_irq($urandom);
    wait_done("rdl");
    build_expected(per, 1'b1, 2);
    compare_log("rdl", base);
    check("rdl_event_count", event_count, 16'd2);
    check("rdl_sv_pulses", sv_cnt - sv0, 2);
    do_reset();

    // stop and irq in the same WAIT_IRQ cycle
    per = $urandom;
    base = wr_q.size(); sv0 = sv_cnt;
    pulse_start(per, 1'b1);
    wait_log(base + 3, "sim_hdr");
    @(negedge clk);
    irq_fire = 1'b1;
    @(negedge clk);
    irq_fire = 1'b0;
    pulse_stop();
    wait_done("sim");
    build_expected(per, 1'b1, 0);
    compare_log("sim", base);
    check("sim_event_count", event_count, 16'd0);
    check("sim_sv_pulses", sv_cnt - sv0, 0);
    do_reset();

    // second start while busy is ignored
    per  = $urandom;
    per2 = ~per;
    base = wr_q.size();
    pulse_start(per, 1'b0);
    pulse_start(per2, 1'b1);
    v = $urandom;
    fire_irq(v);
    wait_done("dbl");
    build_expected(per, 1'b0, 1);
    compare_log("dbl", base);
    check("dbl_snapshot", snapshot, v);

    // reset during WAIT_IRQ, then a clean run
    per = $urandom;
    pulse_start(per, 1'b1);
    fire_irq($urandom);
    wait_sv("mid_sv");
    check("mid_evt_before", event_count, 16'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_cs", avm_chipselect, 1'b0);
    check("mid_write_n", avm_write_n, 1'b1);
    check("mid_busy", busy, 1'b0);
    check("mid_event_count", event_count, 16'd0);
    check("mid_snapshot", snapshot, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    per2 = $urandom;
    base = wr_q.size(); sv0 = sv_cnt;
    pulse_start(per2, 1'b0);
    v = $urandom;
    fire_irq(v);
    wait_done("post");
    build_expected(per2, 1'b0, 1);
    compare_log("post", base);
    check("post_snapshot", snapshot, v);
    check("post_event_count", event_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
